// File: rtl/mem_burst_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mem_pkg                                                   |
// | Purpose  : Shared FSM state encoding and output FIFO depth for the   |
// |            memory burst reader and its skid FIFO.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mem_pkg;

  // Burst reader control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Entries in the output FIFO; also bounds issued-but-unaccepted reads
  localparam int FIFO_DEPTH = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_burst_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: mem_burst_reader_if                                       |
// | Purpose  : Valid/ready word stream produced by the burst reader.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface mem_burst_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // Producer side (the burst reader)
  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  // Consumer side (downstream logic)
  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface : mem_burst_reader_if
`default_nettype wire

// File: rtl/mem_burst_reader_skid_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : skid_fifo2                                                |
// | Purpose  : Two-entry valid/ready FIFO with synchronous flush and an  |
// |            occupancy output. The head entry always drives the output.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module skid_fifo2
  import mem_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occupancy
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_kept;

  assign o_out_valid = (count_q != 2'd0);
  // A full FIFO can still take a word when the head leaves in the same cycle
  assign o_in_ready  = (count_q < 2'(FIFO_DEPTH)) || i_out_ready;
  assign o_out_data  = head_q;
  assign o_occupancy = count_q;
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  // Next-state: shift tail into head on pop, write new word behind survivors
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    w_kept  = count_q - {1'b0, w_pop};
    if (w_pop) begin
      head_d = tail_q;
    end
    if (w_push) begin
      if (w_kept == 2'd0) begin
        head_d = i_in_data;
      end else begin
        tail_d = i_in_data;
      end
    end
    count_d = w_kept + {1'b0, w_push};
    if (i_flush) begin
      count_d = 2'd0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule : skid_fifo2
`default_nettype wire

// File: rtl/mem_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_burst_reader                                          |
// | Purpose  : Reads a burst of words from a synchronous memory (data    |
// |            registered on negedge) starting at a wrapping base        |
// |            address and streams them out over valid/ready, with      |
// |            abort and backpressure-safe read issue.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] burst_len,
  input  logic                     abort,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  mem_burst_reader_if.master       m_if,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_W    = ADDRESS_WIDTH'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LAST = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;          // next address to issue
  logic [ADDRESS_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                     inflight_q, inflight_d;  // read data arrives next edge
  logic                     inflight_last_q, inflight_last_d;
  logic                     done_q, done_d;

  logic                     w_fifo_in_ready;
  logic                     w_fifo_out_valid;
  logic [DATA_WIDTH:0]      w_fifo_out_word;
  logic [1:0]               w_occupancy;
  logic                     w_pop;
  logic                     w_final_accept;
  logic                     w_flush;
  logic [2:0]               w_slots_used;

  assign w_pop          = w_fifo_out_valid & m_if.m_ready;
  assign w_final_accept = w_pop & w_fifo_out_word[DATA_WIDTH];
  assign w_flush        = abort & (state_q != IDLE);
  // Slots committed after this cycle: a word leaving now frees its slot
  assign w_slots_used   = 3'(w_occupancy) + 3'(inflight_q) - 3'(w_pop);

  skid_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_flush),
    .i_in_valid  (inflight_q),
    .o_in_ready  (w_fifo_in_ready),
    .i_in_data   ({inflight_last_q, mem_dataOut}),
    .o_out_valid (w_fifo_out_valid),
    .i_out_ready (m_if.m_ready),
    .o_out_data  (w_fifo_out_word),
    .o_occupancy (w_occupancy)
  );

  // Next-state, read issue and completion logic
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    mem_addr_d      = mem_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d     = ISSUE;
            addr_d      = base_addr % DEPTH_W;
            remaining_d = burst_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if ((w_slots_used < 3'(FIFO_DEPTH)) && w_fifo_in_ready) begin
          mem_addr_d      = addr_q;
          addr_d          = (addr_q == DEPTH_LAST) ? '0 : addr_q + ADDRESS_WIDTH'(1);
          remaining_d     = remaining_q - ADDRESS_WIDTH'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == ADDRESS_WIDTH'(1));
          if (remaining_q == ADDRESS_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (w_final_accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything else, including a same-cycle final accept
    if (w_flush) begin
      state_d         = IDLE;
      mem_addr_d      = mem_addr_q;
      remaining_d     = '0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b1;
    end
  end

  // Control and address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      mem_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      mem_addr_q      <= mem_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  assign mem_wEn      = 1'b0;
  assign mem_dataIn   = '0;
  assign mem_addr     = mem_addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign m_if.m_valid = w_fifo_out_valid;
  assign m_if.m_data  = w_fifo_out_word[DATA_WIDTH-1:0];
  assign m_if.m_last  = w_fifo_out_valid & w_fifo_out_word[DATA_WIDTH];

endmodule : mem_burst_reader
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_burst_reader                                       |
// | Purpose  : Self-checking bench: behavioural word-queue model plus    |
// |            hand-computed burst timelines, abort and reset cases.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mem_burst_reader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 18;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] burst_len = '0;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut = '0;
  logic          busy;
  logic          done;

  mem_burst_reader_if #(.DATA_WIDTH(DW)) m_if ();

  logic [DW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  mem_burst_reader #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .burst_len   (burst_len),
    .abort       (abort),
    .mem_wEn     (mem_wEn),
    .mem_addr    (mem_addr),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .m_if        (m_if),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory contents: word i holds i+100
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
  end

  // Memory registers read data on the falling edge
  always @(negedge clk) begin
    mem_dataOut <= (mem_addr < AW'(DEPTH)) ? mem[mem_addr[4:0]] : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: queue of words the burst must deliver in order
  // ------------------------------------------------------------------
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  word_t exp_q[$];
  int    exp_addr[64];
  int    exp_len    = 0;
  int    accepted   = 0;
  bit    mdl_busy   = 1'b0;
  bit    seen_valid = 1'b0;
  bit    pend_done  = 1'b0;
  bit    ok;
  word_t head;
  word_t w;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        mdl_busy   = 1'b0;
        pend_done  = 1'b0;
        seen_valid = 1'b0;
        accepted   = 0;
        exp_len    = 0;
      end else begin
        check("done", done, pend_done);
        check("busy", busy, mdl_busy);
        check("mem_wEn", mem_wEn, 0);
        check("mem_dataIn", mem_dataIn, 0);
        check("addr_range", mem_addr < AW'(DEPTH), 1);
        if (m_if.m_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", m_if.m_valid, 0);
          end else begin
            seen_valid = 1'b1;
            check("m_data", m_if.m_data, exp_q[0].data);
            check("m_last", m_if.m_last, exp_q[0].last);
          end
        end
        // The last issued address may be at most two words past acceptance
        if (mdl_busy && seen_valid) begin
          ok = 1'b0;
          for (int j = 0; j < exp_len && j <= accepted + 1; j++) begin
            if (int'(mem_addr) == exp_addr[j]) ok = 1'b1;
          end
          check("addr_ahead", ok, 1);
        end

        pend_done = 1'b0;
        if (mdl_busy && abort) begin
          exp_q.delete();
          mdl_busy  = 1'b0;
          pend_done = 1'b1;
        end else if (mdl_busy) begin
          if (m_if.m_valid && m_if.m_ready && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            accepted++;
            if (head.last) begin
              mdl_busy  = 1'b0;
              pend_done = 1'b1;
            end
          end
        end else if (start) begin
          if (burst_len == '0) begin
            pend_done = 1'b1;
          end else begin
            exp_len    = int'(burst_len);
            accepted   = 0;
            seen_valid = 1'b0;
            mdl_busy   = 1'b1;
            for (int i = 0; i < exp_len; i++) begin
              exp_addr[i] = (int'(base_addr) + i) % DEPTH;
              w.last      = (i == exp_len - 1);
              w.data      = DW'(exp_addr[i] + 100);
              exp_q.push_back(w);
            end
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic drive_start(input int b, input int l);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    burst_len = AW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  // Four-word burst with m_ready high: literal timeline from the start edge
  task automatic run_four(input string tag, input int b,
                          input int d0, input int d1, input int d2, input int d3,
                          input int a0, input int a1, input int a2, input int a3);
    int dv[4];
    int av[4];
    dv = '{d0, d1, d2, d3};
    av = '{a0, a1, a2, a3};
    m_if.m_ready = 1'b1;
    drive_start(b, 4);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        check({tag, "_valid"}, m_if.m_valid, 1);
        check({tag, "_data"}, m_if.m_data, dv[k-2]);
        check({tag, "_last"}, m_if.m_last, (k == 5));
      end else begin
        check({tag, "_novalid"}, m_if.m_valid, 0);
      end
      if (k >= 1 && k <= 4) check({tag, "_addr"}, mem_addr, av[k-1]);
      check({tag, "_done"}, done, (k == 6));
    end
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    m_if.m_ready = 1'b1;
    #12;
    check("rst_valid", m_if.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", m_if.m_data, 0);
    check("rst_last", m_if.m_last, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contiguous burst and wrapping burst
    run_four("t1", 3, 103, 104, 105, 106, 3, 4, 5, 6);
    run_four("t2", 16, 116, 117, 100, 101, 16, 17, 0, 1);

    // Backpressure: m_ready 1,0,0 repeating
    drive_start(7, 5);
    for (int c = 0; c < 40; c++) begin
      m_if.m_ready = ((c % 3) == 0);
      @(posedge clk); #1;
    end
    m_if.m_ready = 1'b1;
    check("t3_idle", busy, 0);
    check("t3_words", accepted, 5);

    // Abort in the third cycle of an 8-word burst, then restart
    drive_start(0, 8);
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("t4_pre_valid", m_if.m_valid, 1);
    @(posedge clk); #1;
    abort     = 1'b0;
    start     = 1'b1;
    base_addr = AW'(5);
    burst_len = AW'(1);
    @(negedge clk);
    check("t4_valid_low", m_if.m_valid, 0);
    check("t4_done", done, 1);
    check("t4_busy_low", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_restart_busy", busy, 1);
    check("t4_done_once", done, 0);
    wait_idle("t4_restart_idle");

    // Abort while idle
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_done", done, 0);
    check("idle_abort_busy", busy, 0);

    // Asynchronous reset between edges mid-burst
    drive_start(2, 8);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t5_pre_valid", m_if.m_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_valid", m_if.m_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_data", m_if.m_data, 0);
    check("t5_last", m_if.m_last, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(9);
    burst_len = AW'(0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t5_zero_done", done, 1);
    check("t5_zero_addr", mem_addr, 0);
    check("t5_zero_busy", busy, 0);
    @(negedge clk);
    check("t5_zero_done_once", done, 0);

    // Randomised traffic: starts (also while busy), aborts, backpressure
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      m_if.m_ready = ($urandom_range(0, 3) != 0);
      abort        = ($urandom_range(0, 39) == 0);
      start        = ($urandom_range(0, 5) == 0);
      base_addr    = AW'($urandom_range(0, DEPTH - 1));
      burst_len    = AW'($urandom_range(0, 10));
    end
    @(posedge clk); #1;
    start        = 1'b0;
    abort        = 1'b0;
    m_if.m_ready = 1'b1;
    wait_idle("rand_final_idle");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_burst_reader
`default_nettype wire
